sync_fifo: RTL
==============

Name: sync_fifo

Overview:
- Parametrised single-clock FIFO for the SpartanXL fabric. It buffers data between producer and consumer logic inside the FPGA, for example between the host bus interface and the serial/1-wire engines.
- Data width, depth and threshold flags are generic.
- It provides a fill level, almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- The storage array has no reset, so it maps onto distributed RAM.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH (16 by default)
ALMOST_FULL_LEVEL, 12, almost_full asserted when level >= this value
ALMOST_EMPTY_LEVEL, 2, almost_empty asserted when level <= this value

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous discard of all contents
clear_errors  in  1  clears the overflow and underflow flags
write_en  in  1  write request
write_data  in  DATA_WIDTH  word to store
read_en  in  1  read request
read_data  out  DATA_WIDTH  registered output word
read_valid  out  1  one-cycle pulse: read_data updated this cycle
level  out  ADDR_WIDTH+1  number of stored words, 0..depth
full  out  1  level == depth
empty  out  1  level == 0
almost_full  out  1  level >= ALMOST_FULL_LEVEL
almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset values:
  - read_data = 0, read_valid = 0, level = 0, overflow = 0, underflow = 0.
  - Write and read pointers = 0, so empty = 1, full = 0, almost_empty = 1, almost_full = 0 (when ALMOST_FULL_LEVEL > 0).
  - Array contents are undefined after reset but never observable.
- Accept rules, evaluated on the pre-edge state:
  - write accepted iff write_en & ~full.
  - read accepted iff read_en & ~empty.
- Simultaneous read and write:
  - At 0 < level < depth, both are accepted and level is unchanged.
  - When full, the read is accepted and the write is rejected.
  - When empty, the write is accepted and the read is rejected. There is no write-to-read bypass.
- Write: the word is stored at the write pointer, and the pointer increments modulo depth (natural ADDR_WIDTH wrap).
- Read latency is 1 cycle:
  - read_data is loaded from the read pointer on the edge where the read is accepted, and read_valid is high for exactly the following cycle.
  - The read pointer increments modulo depth.
  - read_data holds its last value when no read is accepted.
- level: a registered counter, +1 on write-only, -1 on read-only, unchanged otherwise. full, empty, almost_full and almost_empty are combinational decodes of level.
- Error flags:
  - overflow is set on a rejected write_en; underflow is set on a rejected read_en.
  - Both are cleared only by reset or clear_errors.
  - If clear_errors coincides with a new error, the set wins.
- flush:
  - Pointers and level go to 0 and read_valid goes to 0 next cycle.
  - flush has priority over write_en and read_en in the same cycle: neither is accepted and neither sets an error flag.
  - read_data holds its value.
  - Error flags are not affected.
- reset has priority over flush and all other inputs. Reset mid-stream discards the contents and forces all reset values on the next edge.
- Legal parameter range:
  - ADDR_WIDTH >= 1.
  - 0 <= ALMOST_EMPTY_LEVEL <= depth.
  - 0 < ALMOST_FULL_LEVEL <= depth.
  - Out-of-range values are a simulation $error.

Test Plan:
- Fill: reset, then write 0x01..0x10 on consecutive cycles.
  - level counts 1..16.
  - almost_empty drops at level 3, almost_full rises at level 12, full rises at level 16.
  - A 17th write of 0xFF sets overflow = 1 and level stays 16.
- Drain: read 16 times back-to-back from the full FIFO.
  - read_data = 0x01..0x10 in order, each with read_valid one cycle after read_en.
  - empty = 1 after the last read. A 17th read sets underflow = 1, read_valid stays 0, and read_data holds 0x10.
- Concurrent and wrap:
  - Preload 5 words, then assert read_en and write_en together for 40 cycles with incrementing data.
  - level stays 5 throughout, output order is preserved across 2+ pointer wraps, and no error flags are set.
- Boundary concurrency:
  - When full, read+write: output 0x01, overflow = 1, level goes to 15.
  - When empty, read+write of 0xAA: level goes to 1, underflow = 1, and the next read returns 0xAA.
- Flush and errors: with level 7, overflow = 1 and flush + write_en asserted:
  - level goes to 0, empty = 1, and overflow remains 1.
  - clear_errors then gives overflow = 0; clear_errors coinciding with a rejected write leaves overflow = 1.
- Reset mid-operation: assert reset during a streaming read at level 9.
  - All outputs take their reset values next cycle, including read_data = 0.
  - A subsequent write then read of 0x5A returns 0x5A.

Source files
------------

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO that buffers words between producer and consumer logic
//   inside the FPGA, for example between the host bus interface and the
//   serial/1-wire engines.
//   The storage array has no reset, so it can map onto distributed RAM.
//
// Ports
//   clk           system clock; all logic runs on the rising edge
//   reset         synchronous, active-high reset; overrides every other input
//   flush         synchronous discard of all contents (read_data is kept)
//   clear_errors  clears the sticky overflow/underflow flags
//   write_en      write request; accepted when the FIFO is not full
//   write_data    word to store
//   read_en       read request; accepted when the FIFO is not empty
//   read_data     registered output word, loaded on an accepted read
//   read_valid    one-cycle pulse: read_data was updated on the last edge
//   level         number of stored words, 0..depth
//   full / empty  level == depth / level == 0
//   almost_full   level >= ALMOST_FULL_LEVEL
//   almost_empty  level <= ALMOST_EMPTY_LEVEL
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clear_errors,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Level-width thresholds, so every compare is between equal widths.
    localparam logic [ADDR_WIDTH:0]   DEPTH_LVL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AF_LVL    = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_LVL    = ALMOST_EMPTY_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LVL_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   LVL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Elaboration-time rejection of parameter values outside the legal range.
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("sync_fifo: ADDR_WIDTH must be >= 1");
    end
    if ((ALMOST_EMPTY_LEVEL < 0) || (ALMOST_EMPTY_LEVEL > DEPTH)) begin : g_bad_ae_level
        $error("sync_fifo: ALMOST_EMPTY_LEVEL must be within 0..depth");
    end
    if ((ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > DEPTH)) begin : g_bad_af_level
        $error("sync_fifo: ALMOST_FULL_LEVEL must be within 1..depth");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q,     wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,     rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q,      level_d;
    logic [DATA_WIDTH-1:0] read_data_q,  read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  overflow_q,   overflow_d;
    logic                  underflow_q,  underflow_d;

    logic full_s;
    logic empty_s;
    logic wr_accept_s;
    logic rd_accept_s;
    logic wr_reject_s;
    logic rd_reject_s;

    // Status decodes of the level counter and the accept/reject decisions.
    // flush suppresses both acceptance and error detection for its cycle.
    always_comb begin
        full_s      = (level_q == DEPTH_LVL);
        empty_s     = (level_q == LVL_ZERO);
        wr_accept_s = write_en & ~full_s  & ~flush;
        rd_accept_s = read_en  & ~empty_s & ~flush;
        wr_reject_s = write_en &  full_s  & ~flush;
        rd_reject_s = read_en  &  empty_s & ~flush;
    end

    // Next-state computation for pointers, level, read port and error flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        read_data_d  = read_data_q;
        read_valid_d = rd_accept_s;

        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            level_d  = LVL_ZERO;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_accept_s) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                read_data_d = mem_q[rd_ptr_q];
            end else begin
                rd_ptr_d    = rd_ptr_q;
                read_data_d = read_data_q;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end

        // A new error outranks a coincident clear.
        if (wr_reject_s) begin
            overflow_d = 1'b1;
        end else if (clear_errors) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (rd_reject_s) begin
            underflow_d = 1'b1;
        end else if (clear_errors) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= PTR_ZERO;
            rd_ptr_q     <= PTR_ZERO;
            level_q      <= LVL_ZERO;
            read_data_q  <= DATA_ZERO;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array: deliberately without reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_accept_s & ~reset) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    assign read_data    = read_data_q;
    assign read_valid   = read_valid_q;
    assign level        = level_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
